// File: rtl/mpe_gene_aligner.sv
// NEAT gene aligner feeding the mpe PE: setup beat, aligned gene pairs, LFSR pack, child strobe.
// Define MPE_ALIGN_KEYCHK_EN to add per-stream key-order checking and the key_err output.
module mpe_gene_aligner #(
   parameter int unsigned WORD_SZ    = 64,
   parameter int unsigned GENE_SZ    = 64,
   parameter int unsigned ATTR_SZ    = 8,
   parameter int unsigned PE_LATENCY = 3,
   parameter logic [31:0] LFSR_SEED  = 32'h1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WORD_SZ-1:0] cfg_word,
   input  logic [ATTR_SZ-1:0] child_id,
   input  logic [GENE_SZ-1:0] p1_gene,
   input  logic               p1_valid,
   input  logic               p1_last,
   output logic               p1_ready,
   input  logic [GENE_SZ-1:0] p2_gene,
   input  logic               p2_valid,
   input  logic               p2_last,
   output logic               p2_ready,
   output logic               pe_setup,
   output logic [WORD_SZ-1:0] pe_data_in1,
   output logic [WORD_SZ-1:0] pe_data_in2,
   output logic [WORD_SZ-1:0] pe_random_num_pack,
   output logic               pe_gene_valid,
   output logic               child_valid,
   output logic               busy,
   output logic               done
`ifdef MPE_ALIGN_KEYCHK_EN
   ,
   output logic               key_err
`endif
);

   localparam logic [31:0] LfsrTaps = 32'h80200003;
   localparam logic [31:0] LfsrInit = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
   localparam int unsigned CntW     = $clog2(PE_LATENCY + 1);

   typedef enum logic [2:0] {StIdle, StSetup, StMerge, StDrain, StDone} state_e;

   state_e              state_q, state_d;
   logic [WORD_SZ-1:0]  cfg_q;
   logic [ATTR_SZ-1:0]  id_q;
   logic                ex1_q, ex2_q, ex1_d, ex2_d;
   logic [31:0]         lfsr_q, lfsr_next;
   logic [CntW-1:0]     cnt_q;
   logic [PE_LATENCY-1:0] vsr_q, vsr_d;
   logic [15:0]         key1, key2;
   logic                h1, h2, pop1, pop2, issue, p2_fitter;
   logic [GENE_SZ-1:0]  pair_a, pair_b;

   assign key1      = p1_gene[55:40];
   assign key2      = p2_gene[55:40];
   assign h1        = p1_valid && !ex1_q;
   assign h2        = p2_valid && !ex2_q;
   // Tie goes to p1, matching the PE bias rule.
   assign p2_fitter = cfg_q[55:48] > cfg_q[63:56];
   assign ex1_d     = ex1_q | (pop1 & p1_last);
   assign ex2_d     = ex2_q | (pop2 & p2_last);
   assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LfsrTaps : 32'h0);
   assign vsr_d     = PE_LATENCY'({vsr_q, pe_gene_valid});
   assign child_valid = vsr_q[PE_LATENCY-1];
   assign p1_ready  = pop1;
   assign p2_ready  = pop2;

   // Merge decision: at most one action per cycle.
   always_comb begin
      pop1   = 1'b0;
      pop2   = 1'b0;
      issue  = 1'b0;
      pair_a = p1_gene;
      pair_b = p2_gene;
      if (state_q == StMerge) begin
         if (h1 && h2) begin
            if (key1 == key2) begin
               pop1  = 1'b1;
               pop2  = 1'b1;
               issue = 1'b1;
            end else if (key1 < key2) begin
               pop1   = 1'b1;
               issue  = !p2_fitter;
               pair_b = p1_gene;
            end else begin
               pop2   = 1'b1;
               issue  = p2_fitter;
               pair_a = p2_gene;
            end
         end else if (ex2_q && h1) begin
            pop1   = 1'b1;
            issue  = !p2_fitter;
            pair_b = p1_gene;
         end else if (ex1_q && h2) begin
            pop2   = 1'b1;
            issue  = p2_fitter;
            pair_a = p2_gene;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StSetup;
         StSetup: state_d = StMerge;
         StMerge: if (ex1_d && ex2_d) state_d = StDrain;
         StDrain: if (cnt_q == CntW'(PE_LATENCY - 1)) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy               = (state_q != StIdle);
      pe_setup           = 1'b0;
      pe_gene_valid      = 1'b0;
      pe_data_in1        = '0;
      pe_data_in2        = '0;
      pe_random_num_pack = '0;
      done               = 1'b0;
      unique case (state_q)
         StSetup: begin
            pe_setup    = 1'b1;
            pe_data_in1 = cfg_q;
            pe_data_in2 = WORD_SZ'(id_q);
         end
         StMerge: begin
            if (issue) begin
               pe_gene_valid = 1'b1;
               pe_data_in1   = WORD_SZ'(pair_a);
               pe_data_in2   = WORD_SZ'(pair_b);
            end
         end
         StDone:  done = 1'b1;
         default: ;
      endcase
      if (state_q != StIdle) pe_random_num_pack = WORD_SZ'(lfsr_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_q  <= '0;
         id_q   <= '0;
         ex1_q  <= 1'b0;
         ex2_q  <= 1'b0;
         lfsr_q <= LfsrInit;
         cnt_q  <= '0;
         vsr_q  <= '0;
      end else begin
         if (state_q == StIdle && start) begin
            cfg_q <= cfg_word;
            id_q  <= child_id;
            ex1_q <= 1'b0;
            ex2_q <= 1'b0;
         end else begin
            ex1_q <= ex1_d;
            ex2_q <= ex2_d;
         end
         if (issue) lfsr_q <= lfsr_next;
         cnt_q <= (state_q == StDrain) ? cnt_q + 1'b1 : '0;
         vsr_q <= vsr_d;
      end
   end

`ifdef MPE_ALIGN_KEYCHK_EN
   logic [15:0] last1_q, last2_q;
   logic        seen1_q, seen2_q, key_err_q;

   // First key of each stream within a genome has nothing to compare against.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last1_q   <= '0;
         last2_q   <= '0;
         seen1_q   <= 1'b0;
         seen2_q   <= 1'b0;
         key_err_q <= 1'b0;
      end else if (state_q == StIdle && start) begin
         seen1_q   <= 1'b0;
         seen2_q   <= 1'b0;
         key_err_q <= 1'b0;
      end else begin
         if (pop1) begin
            if (seen1_q && key1 <= last1_q) key_err_q <= 1'b1;
            last1_q <= key1;
            seen1_q <= 1'b1;
         end
         if (pop2) begin
            if (seen2_q && key2 <= last2_q) key_err_q <= 1'b1;
            last2_q <= key2;
            seen2_q <= 1'b1;
         end
      end
   end

   assign key_err = key_err_q;
`endif

endmodule

// File: doc/mpe_gene_aligner.md
# mpe_gene_aligner

Upstream feeder for the mutation/crossover PE (`mpe`). Takes two parent genomes as key-sorted gene streams and emits the configuration setup beat for the PE. It then emits NEAT-aligned gene pairs, one per cycle: matching keys are paired, disjoint/excess genes of the fitter parent are self-paired, and those of the weaker parent are dropped. It also supplies the PE's random number pack and a `child_valid` strobe aligned with the PE's `child_gene` output.

## Interface
- `WORD_SZ`, 64, PE data word width
- `GENE_SZ`, 64, gene width; key field = gene[55:40], gene type = bit 55
- `ATTR_SZ`, 8, attribute width
- `PE_LATENCY`, 3, cycles from a gene beat on `pe_data_in*` to the matching `child_gene`
- `LFSR_SEED`, 32'h1, LFSR reset value; 0 is illegal and is replaced by 1
- `clk` in 1 — clock, all state on rising edge
- `rst` in 1 — reset, asynchronous, active-low (0 = reset)
- `start` in 1 — begin one child genome; sampled only in IDLE
- `cfg_word` in 64 — {p1_fit, p2_fit, 6 mutation probs}; latched on `start`
- `child_id` in 8 — child genome id; latched on `start`
- `p1_gene` in 64, `p1_valid` in 1, `p1_last` in 1, `p1_ready` out 1 — parent-1 stream, keys strictly ascending
- `p2_gene` in 64, `p2_valid` in 1, `p2_last` in 1, `p2_ready` out 1 — parent-2 stream, same rules
- `pe_setup` out 1 — drives PE `setup`
- `pe_data_in1`, `pe_data_in2` out 64 — drive PE `data_in1`/`data_in2`
- `pe_random_num_pack` out 64 — {32'b0, lfsr}
- `child_valid` out 1 — PE `child_gene` holds a real child gene this cycle
- `busy` out 1 — high in every state other than IDLE
- `done` out 1 — one-cycle pulse at end of genome
- `key_err` out 1 — sticky order error; only present with `MPE_ALIGN_KEYCHK_EN`

## Operation
- Each stream beat is consumed when `valid && ready`. `last` marks a parent's final gene. Every parent has at least one gene.
- Fitter parent is p2 iff `cfg[55:48] > cfg[63:56]`. A tie selects p1, which matches the PE bias rule.
- FSM states: IDLE, SETUP, MERGE, DRAIN, DONE.
- IDLE: all outputs 0. `start=1` latches `cfg_word` and `child_id`, then goes to SETUP. `start` in any other state is ignored.
- SETUP (1 cycle): drives `pe_setup=1`, `pe_data_in1=cfg`, `pe_data_in2={56'b0,child_id}`. Next state is MERGE.
- MERGE: each stream has an `ex` (exhausted) flag, set when its `last` beat is consumed. At most one action per cycle, in this priority:
  - Both heads valid and keys equal: issue (p1, p2) and pop both.
  - Both heads valid and key1 < key2: pop p1. Issue (p1, p1) if p1 is fitter; otherwise drop.
  - Both heads valid and key2 < key1: symmetric to the above.
  - Exactly one stream exhausted and the other head valid: pop it. Issue the self-pair if it belongs to the fitter parent; otherwise drop.
  - Otherwise: bubble.
- Both `ex` set: go to DRAIN.
- Issue means `pe_gene_valid=1`, `pe_data_in1`/`pe_data_in2` = pair, and the LFSR advances. Drop or bubble means `pe_gene_valid=0` and data = 0.
- `pe_setup` is 0 in every state other than SETUP.
- `ready` is combinational from head compare and state; it is never asserted outside MERGE.
- LFSR: 32-bit Galois, taps 32'h80200003, shifts right. It advances only on issue cycles.
- `child_valid` is `pe_gene_valid` delayed by a `PE_LATENCY`-deep shift register that clears on reset.
- DRAIN: counts `PE_LATENCY` cycles, then goes to DONE. DONE: `done=1` for 1 cycle, then IDLE.
- Reset mid-genome: FSM returns to IDLE, `ex` and shift register clear, LFSR returns to seed, and in-flight stream beats are not consumed.

## Timing
- `start` at cycle t puts SETUP at t+1. The earliest issue is at t+2.
- Throughput is 1 beat per cycle with no bubbles when both heads stay valid.
- Issue at cycle c produces `child_valid` at c+PE_LATENCY.
- The last consume at cycle c produces `done` at c+1+PE_LATENCY. The next `start` is accepted at the cycle after `done`.

## Configuration
- `MPE_ALIGN_KEYCHK_EN` defined:
  - Each stream registers its last consumed key.
  - A consumed key ≤ the previous key of the same stream (within one genome) sets `key_err`.
  - `key_err` clears only on reset or `start`. Alignment behaviour is unchanged.
- Not defined: no key registers, and the `key_err` port is absent.

## Test plan
- Equal genomes: p1 keys {1,2,3}, p2 keys {1,2,3}, p1_fit=9, p2_fit=4 → setup beat, then 3 issues (pairs) on consecutive cycles, 3 `child_valid` pulses PE_LATENCY later, `done` once.
- Disjoint, p1 fitter: p1 {1,3,5}, p2 {1,2,4,6}, fits 9/4 → issues 1:(p1,p2), 3:(p1,p1), 5:(p1,p1). Keys 2, 4, 6 are dropped. `child_valid` count = 3.
- Tie fitness 5/5 with p2 excess {7,8} after a common {1} → p1 is fitter, so 7 and 8 are dropped and exactly 1 issue occurs.
- Stalls: p2_valid toggles 0/1 every cycle → bubbles carry `pe_gene_valid=0` and the LFSR does not advance. The issue sequence is identical to the no-stall run, and `pe_random_num_pack` per issue matches the reference LFSR sequence from seed 1.
- Reset (rst=0) asserted in MERGE after 2 issues → all outputs 0 immediately and no `done`. A fresh `start` replays from setup with LFSR = seed.
- With `MPE_ALIGN_KEYCHK_EN`: p1 keys {3,2} → `key_err=1` after the 2nd pop, held until the next `start`.
